// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at the start edge and held pending until the busy window expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [31:0] r_cnt, r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic        w_md, w_div, w_idle;
  logic [63:0] w_smul, w_umul, w_res;
  logic [31:0] w_abs_a, w_abs_b, w_sb, w_ub, w_sq, w_sr, w_sq_s, w_sr_s, w_uq, w_ur;
  assign w_idle  = r_state == IDLE;
  assign w_md    = start && op != 3'd0 && op <= 3'd4;
  assign w_div   = op[2] || op == 3'd3;
  assign w_smul  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_umul  = {32'd0, A} * {32'd0, B};
  // Divide on magnitudes so the most-negative / -1 case wraps instead of overflowing.
  assign w_abs_a = A[31] ? -A : A;
  assign w_abs_b = B[31] ? -B : B;
  assign w_sb    = (B == 32'd0) ? 32'd1 : w_abs_b;
  assign w_ub    = (B == 32'd0) ? 32'd1 : B;
  assign w_sq    = w_abs_a / w_sb;
  assign w_sr    = w_abs_a % w_sb;
  assign w_sq_s  = (A[31] ^ B[31]) ? -w_sq : w_sq;
  assign w_sr_s  = A[31] ? -w_sr : w_sr;
  assign w_uq    = A / w_ub;
  assign w_ur    = A % w_ub;
  assign w_res   = (op == 3'd1) ? w_smul :
                   (op == 3'd2) ? w_umul :
                   (B == 32'd0) ? {r_hi, r_lo} :
                   (op == 3'd3) ? {w_sr_s, w_sq_s} : {w_ur, w_uq};
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = w_idle ? (w_md ? RUN : IDLE) : ((r_cnt == 32'd0) ? IDLE : RUN);
  end
  always_comb begin
    busy      = r_state == RUN;
    stall_req = busy | w_md;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (w_idle) begin
      if (w_md) begin
        r_cnt     <= w_div ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
        r_pend_hi <= w_res[63:32];
        r_pend_lo <= w_res[31:0];
      end
      if (start && op == 3'd5) r_hi <= A;
      if (start && op == 3'd6) r_lo <= A;
    end else if (r_cnt == 32'd0) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end else r_cnt <= r_cnt - 32'd1;
  assign HI = r_hi;
  assign LO = r_lo;
endmodule
